// File: rtl/control_acumulador_pkg.sv
// ============================================================================
// Module   : control_acumulador_pkg
// Purpose  : State encoding and overrun-counter constants for the MAC sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package control_acumulador_pkg;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        DESPLAZA = 2'd1,
        ACUMULA  = 2'd2,
        LISTO    = 2'd3
    } estado_t;

    localparam int                   CNT_SOB_W   = 8;
    localparam logic [CNT_SOB_W-1:0] CNT_SOB_MAX = 8'd255;

endpackage

`default_nettype wire

// File: rtl/control_acumulador_contador_taps.sv
// ============================================================================
// Module   : contador_taps
// Purpose  : Tap index counter with load-to-zero, enable and terminal flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module contador_taps #(
    parameter int N_TAPS = 4,
    parameter int IDX_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cargar,
    input  logic             habilitar,
    output logic [IDX_W-1:0] cuenta,
    output logic             terminal
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cuenta <= '0;
        end else if (cargar) begin
            cuenta <= '0;
        end else if (habilitar) begin
            cuenta <= cuenta + 1'b1;
        end
    end

    assign terminal = (cuenta == IDX_W'(N_TAPS - 1));

endmodule

`default_nettype wire

// File: rtl/control_acumulador.sv
// ============================================================================
// Module   : control_acumulador
// Purpose  : Sequencer for the filter MAC datapath (shift, clear, accumulate,
//            done) with sticky overrun detection. Optional macro:
//            CONTADOR_SOBRECARGA_EN adds a saturating overrun counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module control_acumulador
    import control_acumulador_pkg::*;
#(
    parameter int N_TAPS = 4,
    parameter int IDX_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             muestra,
    input  logic             habilitar,
    input  logic             borrar_sob,
    output logic [IDX_W-1:0] sel,
    output logic             desplazar,
    output logic             limpiar,
    output logic             acumular,
    output logic             listo,
    output logic             ocupado,
    output logic             sobrecarga
`ifdef CONTADOR_SOBRECARGA_EN
    ,
    output logic [CNT_SOB_W-1:0] cnt_sobrecarga
`endif
);

    estado_t estado;
    estado_t estado_sig;
    logic    acepta;
    logic    desborde;
    logic    fin_taps;
    logic    cargar_taps;
    logic    avanzar_taps;

    assign acepta       = muestra & habilitar;
    // A strobe is only safe in REPOSO or LISTO; anywhere else it is dropped.
    assign desborde     = acepta & ((estado == DESPLAZA) | (estado == ACUMULA));
    assign avanzar_taps = (estado == ACUMULA);
    assign cargar_taps  = (estado != ACUMULA) | fin_taps;

    contador_taps #(
        .N_TAPS (N_TAPS),
        .IDX_W  (IDX_W)
    ) u_contador_taps (
        .clk       (clk),
        .rst       (rst),
        .cargar    (cargar_taps),
        .habilitar (avanzar_taps),
        .cuenta    (sel),
        .terminal  (fin_taps)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        unique case (estado)
            REPOSO:   if (acepta) estado_sig = DESPLAZA;
            DESPLAZA: estado_sig = ACUMULA;
            ACUMULA:  if (fin_taps) estado_sig = LISTO;
            LISTO:    estado_sig = acepta ? DESPLAZA : REPOSO;
            default:  estado_sig = REPOSO;
        endcase
    end

    // Strobes decode from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            desplazar <= 1'b0;
            limpiar   <= 1'b0;
            acumular  <= 1'b0;
            listo     <= 1'b0;
            ocupado   <= 1'b0;
        end else begin
            desplazar <= (estado_sig == DESPLAZA);
            limpiar   <= (estado_sig == DESPLAZA);
            acumular  <= (estado_sig == ACUMULA);
            listo     <= (estado_sig == LISTO);
            ocupado   <= (estado_sig != REPOSO);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sobrecarga <= 1'b0;
        end else if (desborde) begin
            sobrecarga <= 1'b1;
        end else if (borrar_sob) begin
            sobrecarga <= 1'b0;
        end
    end

`ifdef CONTADOR_SOBRECARGA_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_sobrecarga <= '0;
        end else if (desborde) begin
            if (borrar_sob) begin
                cnt_sobrecarga <= CNT_SOB_W'(1);
            end else if (cnt_sobrecarga != CNT_SOB_MAX) begin
                cnt_sobrecarga <= cnt_sobrecarga + 1'b1;
            end
        end else if (borrar_sob) begin
            cnt_sobrecarga <= '0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_control_acumulador.sv
// ============================================================================
// Module   : tb_control_acumulador
// Purpose  : Self-checking bench: vector table, corner sequences and random
//            stimulus against a timeline model of the sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_control_acumulador;

    localparam int N_TAPS = 4;
    localparam int IDX_W  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             muestra = 1'b0;
    logic             habilitar = 1'b1;
    logic             borrar_sob = 1'b0;
    logic [IDX_W-1:0] sel;
    logic             desplazar, limpiar, acumular, listo, ocupado, sobrecarga;
`ifdef CONTADOR_SOBRECARGA_EN
    logic [7:0]       cnt_sobrecarga;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Model: edge index and the edge at which the current sample was accepted.
    int k        = 0;
    int inicio   = -1000;
    int exp_sob  = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    control_acumulador #(
        .N_TAPS (N_TAPS),
        .IDX_W  (IDX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .muestra    (muestra),
        .habilitar  (habilitar),
        .borrar_sob (borrar_sob),
        .sel        (sel),
        .desplazar  (desplazar),
        .limpiar    (limpiar),
        .acumular   (acumular),
        .listo      (listo),
        .ocupado    (ocupado),
        .sobrecarga (sobrecarga)
`ifdef CONTADOR_SOBRECARGA_EN
        ,
        .cnt_sobrecarga (cnt_sobrecarga)
`endif
    );

    task automatic chk(input string nombre, input int actual, input int esperado);
        n_assert++;
        if (actual != esperado) begin
            n_fail++;
            $display("FAIL %s (edge %0d): got %0d, expected %0d", nombre, k, actual, esperado);
        end
    endtask

    // Expected outputs follow from how many edges have elapsed since acceptance.
    task automatic chk_modelo();
        int d;
        int e_acu;
        d     = k - inicio;
        e_acu = (d >= 2 && d <= N_TAPS + 1) ? 1 : 0;
        chk("desplazar", int'(desplazar), (d == 1) ? 1 : 0);
        chk("limpiar",   int'(limpiar),   (d == 1) ? 1 : 0);
        chk("acumular",  int'(acumular),  e_acu);
        chk("sel",       int'(sel),       e_acu ? d - 2 : 0);
        chk("listo",     int'(listo),     (d == N_TAPS + 2) ? 1 : 0);
        chk("ocupado",   int'(ocupado),   (d >= 1 && d <= N_TAPS + 2) ? 1 : 0);
        chk("sobrecarga", int'(sobrecarga), exp_sob);
`ifdef CONTADOR_SOBRECARGA_EN
        chk("cnt_sobrecarga", int'(cnt_sobrecarga), exp_cnt);
`endif
    endtask

    task automatic step(input logic m, input logic h, input logic b);
        int  d;
        bit  ovr;
        muestra    = m;
        habilitar  = h;
        borrar_sob = b;
        d   = k - inicio;
        ovr = m && h && (d >= 1 && d <= N_TAPS + 1);
        if (m && h && !ovr) inicio = k;
        if (ovr) exp_sob = 1;
        else if (b) exp_sob = 0;
        if (ovr) exp_cnt = b ? 1 : ((exp_cnt < 255) ? exp_cnt + 1 : 255);
        else if (b) exp_cnt = 0;
        @(posedge clk);
        k++;
        #1;
        chk_modelo();
    endtask

    task automatic modelo_reset();
        inicio  = k - 1000;
        exp_sob = 0;
        exp_cnt = 0;
    endtask

    typedef struct {
        logic m, h, b;
        int   sel, desp, acu, lst, ocu, sob;
    } vec_t;

    vec_t tabla [12];

    initial begin
        // Strobes at edges 0 and 3 (second one overruns), clear at edge 10.
        tabla[0]  = '{1, 1, 0, 0, 1, 0, 0, 1, 0};
        tabla[1]  = '{0, 1, 0, 0, 0, 1, 0, 1, 0};
        tabla[2]  = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
        tabla[3]  = '{1, 1, 0, 2, 0, 1, 0, 1, 1};
        tabla[4]  = '{0, 1, 0, 3, 0, 1, 0, 1, 1};
        tabla[5]  = '{0, 1, 0, 0, 0, 0, 1, 1, 1};
        tabla[6]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
        tabla[7]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
        tabla[8]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
        tabla[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
        tabla[10] = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
        tabla[11] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};

        #12;
        modelo_reset();
        chk_modelo();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            step(tabla[i].m, tabla[i].h, tabla[i].b);
            chk("tbl_sel",  int'(sel),        tabla[i].sel);
            chk("tbl_desp", int'(desplazar),  tabla[i].desp);
            chk("tbl_acu",  int'(acumular),   tabla[i].acu);
            chk("tbl_listo", int'(listo),     tabla[i].lst);
            chk("tbl_ocup", int'(ocupado),    tabla[i].ocu);
            chk("tbl_sob",  int'(sobrecarga), tabla[i].sob);
        end

        // Back-to-back: second strobe lands exactly in LISTO.
        step(1, 1, 0);
        for (int i = 1; i < 6; i++) step(0, 1, 0);
        step(1, 1, 0);
        chk("b2b_desplazar", int'(desplazar), 1);
        chk("b2b_sob", int'(sobrecarga), 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0);

        // Habilitar drops mid-computation; later strobe ignored without overrun.
        step(1, 1, 0);
        step(0, 1, 0);
        for (int i = 2; i < 8; i++) step(0, 0, 0);
        step(1, 0, 0);
        chk("hab_ignored_ocup", int'(ocupado), 0);
        chk("hab_ignored_sob", int'(sobrecarga), 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0);

        // Asynchronous reset in the middle of accumulation.
        step(1, 1, 0);
        for (int i = 1; i < 4; i++) step(0, 1, 0);
        #2 rst = 1'b0;
        #1;
        modelo_reset();
        chk("rst_acumular", int'(acumular), 0);
        chk("rst_ocupado", int'(ocupado), 0);
        chk_modelo();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        step(1, 1, 0);
        for (int i = 1; i < 8; i++) step(0, 1, 0);

`ifdef CONTADOR_SOBRECARGA_EN
        // Held strobe: 5 of every 6 edges overrun, enough to saturate.
        for (int i = 0; i < 400; i++) step(1, 1, 0);
        chk("cnt_saturado", int'(cnt_sobrecarga), 255);
        for (int i = 0; i < 8; i++) step(0, 1, 0);
        step(1, 1, 0);
        step(1, 1, 1);
        chk("cnt_set_clear", int'(cnt_sobrecarga), 1);
        chk("sob_set_clear", int'(sobrecarga), 1);
        for (int i = 0; i < 8; i++) step(0, 1, 0);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step(logic'($urandom_range(0, 9) < 4),
                 logic'($urandom_range(0, 9) < 8),
                 logic'($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
